// File: rtl/uart_tx_if.sv
// Handshake between the APB register block and the UART transmitter.
interface uart_tx_if;
   logic       txStart;
   logic [7:0] txData;
   logic       txD;
   logic       busy;
   logic       clrTxStartBit;

   // APB block side: issues the request, sees the line and status
   modport master (
      output txStart, txData,
      input  txD, busy, clrTxStartBit
   );

   // Transmitter side
   modport slave (
      input  txStart, txData,
      output txD, busy, clrTxStartBit
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 11-bit frame (start, 8 data LSB first, parity, stop),
// one bit every CLKS_PER_BIT clocks, one-cycle clrTxStartBit pulse at the end.
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input logic clk,
   input logic rst,
   uart_tx_if.slave bus
);
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_BIT  = 4'd10;
   localparam logic          ODD       = (PARITY_ODD != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t        state;
   logic [10:0]   shiftReg;
   logic [TW-1:0] tick;
   logic [3:0]    bitCnt;
   logic          txDR;
   logic          busyR;
   logic          clrR;
   logic          parity;

   // parity is only consumed on the accepting edge, so txData is sampled once
   assign parity = (^bus.txData) ^ ODD;

   assign bus.txD           = txDR;
   assign bus.busy          = busyR;
   assign bus.clrTxStartBit = clrR;

   // Frame FSM; txD tracks shiftReg[0] by loading the bit that becomes LSB
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         shiftReg <= '1;
         tick     <= '0;
         bitCnt   <= '0;
         txDR     <= 1'b1;
         busyR    <= 1'b0;
         clrR     <= 1'b0;
      end else begin
         clrR <= 1'b0;
         case (state)
            IDLE: begin
               txDR  <= 1'b1;
               busyR <= 1'b0;
               if (bus.txStart) begin
                  shiftReg <= {1'b1, parity, bus.txData, 1'b0};
                  tick     <= '0;
                  bitCnt   <= '0;
                  txDR     <= 1'b0;
                  busyR    <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (tick == LAST_TICK) begin
                  tick <= '0;
                  if (bitCnt == LAST_BIT) begin
                     // stop bit already drives 1, so CLEAR keeps the line glitch-free
                     txDR  <= 1'b1;
                     clrR  <= 1'b1;
                     state <= CLEAR;
                  end else begin
                     bitCnt   <= bitCnt + 4'd1;
                     shiftReg <= {1'b1, shiftReg[10:1]};
                     txDR     <= shiftReg[1];
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            CLEAR: begin
               txDR  <= 1'b1;
               busyR <= 1'b0;
               state <= IDLE;
            end
            default: begin
               txDR  <= 1'b1;
               busyR <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench: stimulus pushes hand-computed frames, a per-DUT line
// monitor decodes txD at mid-bit and compares. Lane 0 even parity, lane 1 odd.
module tb_uart_tx;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       txStart = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       rstQ = 1'b1;

   int tests = 0;
   int fails = 0;
   int expClr = 0;
   int clrSeen [2];
   logic [10:0] expQ [2][$];

   always #5 clk = ~clk;

   // reset as seen by the DUT at the most recent edge
   always @(posedge clk) rstQ <= rst;

   uart_tx_if bus [2] ();

   for (genvar g = 0; g < 2; g++) begin : lane
      assign bus[g].txStart = txStart;
      assign bus[g].txData  = txData;

      uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(g)) dut (
         .clk(clk),
         .rst(rst),
         .bus(bus[g])
      );

      int          off = 0;
      int          busyRun = 0;
      logic        active = 1'b0;
      logic [10:0] cap = '1;
      logic [10:0] expF;

      // line monitor: sample each bit at tick 8, check against scoreboard
      always @(negedge clk) begin
         if (!rstQ) begin
            active = 1'b0;
            busyRun = 0;
            tests++;
            if (bus[g].txD !== 1'b1 || bus[g].busy !== 1'b0 || bus[g].clrTxStartBit !== 1'b0) begin
               fails++;
               $display("FAIL resetIdle[%0d] txD/busy/clr=%b/%b/%b required 1/0/0",
                        g, bus[g].txD, bus[g].busy, bus[g].clrTxStartBit);
            end
         end else begin
            if (bus[g].busy === 1'b1) busyRun++;
            else busyRun = 0;
            if (bus[g].clrTxStartBit === 1'b1) begin
               clrSeen[g]++;
               tests++;
               if (busyRun != 177 || bus[g].txD !== 1'b1) begin
                  fails++;
                  $display("FAIL clrTiming[%0d] busyCycles=%0d txD=%b required 177 and 1",
                           g, busyRun, bus[g].txD);
               end
            end
            if (!active && bus[g].txD === 1'b0) begin
               active = 1'b1;
               off = 0;
            end
            if (active) begin
               if (off % CPB == CPB / 2) cap[off / CPB] = bus[g].txD;
               if (off == 10 * CPB + CPB / 2) begin
                  active = 1'b0;
                  tests++;
                  if (expQ[g].size() == 0) begin
                     fails++;
                     $display("FAIL unexpectedFrame[%0d] got %b required no frame", g, cap);
                  end else begin
                     expF = expQ[g].pop_front();
                     if (cap !== expF) begin
                        fails++;
                        $display("FAIL frame[%0d] got %b required %b (stop,P,d7..d0,start)",
                                 g, cap, expF);
                     end
                  end
               end else begin
                  off++;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expectFrame(input logic [10:0] e0, input logic [10:0] e1);
      expQ[0].push_back(e0);
      expQ[1].push_back(e1);
      expClr++;
   endtask

   // bounded wait on lane 0 busy (sel=0) or clrTxStartBit (sel=1)
   task automatic waitFor(input int sel, input string nm);
      int n = 0;
      while (!((sel == 0) ? (bus[0].busy === 1'b1) : (bus[0].clrTxStartBit === 1'b1)) && n < 400) begin
         tick(1);
         n++;
      end
      if (n >= 400) begin
         tests++;
         fails++;
         $display("FAIL timeout_%s waited %0d cycles required under 400", nm, n);
      end
   endtask

   task automatic sendByte(input logic [7:0] d, input logic [10:0] e0, input logic [10:0] e1);
      expectFrame(e0, e1);
      txData = d;
      txStart = 1'b1;
      tick(1);
      txStart = 1'b0;
      waitFor(1, "clr");
      tick(3);
   endtask

   initial begin
      // reset with txStart asserted: nothing may start
      rst = 1'b0;
      txStart = 1'b1;
      txData = 8'hA5;
      tick(3);
      txStart = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(2);

      // frames as {stop, P, d7..d0, start}; lane 0 even, lane 1 odd parity
      sendByte(8'hA5, 11'b1_0_10100101_0, 11'b1_1_10100101_0);
      sendByte(8'h01, 11'b1_1_00000001_0, 11'b1_0_00000001_0);
      sendByte(8'h00, 11'b1_0_00000000_0, 11'b1_1_00000000_0);

      // txData change and txStart pulse mid-frame are ignored
      expectFrame(11'b1_0_00111100_0, 11'b1_1_00111100_0);
      txData = 8'h3C;
      txStart = 1'b1;
      tick(1);
      txStart = 1'b0;
      tick(3 * CPB + 4);
      txData = 8'hFF;
      txStart = 1'b1;
      tick(1);
      txStart = 1'b0;
      waitFor(1, "clrStable");
      tick(3);

      // reset at bit 5 aborts the frame silently, then a clean resend
      txData = 8'h55;
      txStart = 1'b1;
      tick(1);
      txStart = 1'b0;
      tick(5 * CPB + 4);
      rst = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(2);
      sendByte(8'h55, 11'b1_0_01010101_0, 11'b1_1_01010101_0);

      // back-to-back with txStart held high
      expectFrame(11'b1_0_00000000_0, 11'b1_1_00000000_0);
      expectFrame(11'b1_0_11111111_0, 11'b1_1_11111111_0);
      expectFrame(11'b1_0_01011010_0, 11'b1_1_01011010_0);
      txData = 8'h00;
      txStart = 1'b1;
      tick(1);
      txData = 8'hFF;
      waitFor(1, "clrB2B0");
      tick(2);
      txData = 8'h5A;
      waitFor(1, "clrB2B1");
      tick(2);
      waitFor(1, "clrB2B2");
      txStart = 1'b0;
      tick(20);

      for (int g = 0; g < 2; g++) begin
         tests++;
         if (expQ[g].size() != 0) begin
            fails++;
            $display("FAIL missingFrames[%0d] pending=%0d required 0", g, expQ[g].size());
         end
         tests++;
         if (clrSeen[g] != expClr) begin
            fails++;
            $display("FAIL clrCount[%0d] got %0d required %0d", g, clrSeen[g], expClr);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
